ret_stack_ctrl: RTL and testbench

//  Client-side controller for the 12-bit, 8-entry push/pop LIFO stack. Serves call/return requests from the CPU.

---
 rtl/ca_stack_pkg.sv | 10 +
 rtl/ca_stack.sv | 34 +++
 rtl/ret_stack_ctrl.sv | 93 +++++++++
 tb/tb_ret_stack_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ca_stack_pkg.sv
// ca_stack_pkg: shared widths and types for the return-address stack and its controller
package ca_stack_pkg;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PTR_W  = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, PUSH, POP, WAIT, RESP} stk_state_t;
    typedef logic [ADDR_W-1:0] ret_addr_t;
endpackage

// File: rtl/ca_stack.sv
// ca_stack: 8-entry push/pop LIFO; out is registered on the pop edge and held otherwise
module ca_stack
    import ca_stack_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  ret_addr_t in,
    output ret_addr_t out
);
    ret_addr_t        mem [DEPTH];
    logic [CNT_W-1:0] sp;
    logic [PTR_W-1:0] top;
    logic             full, empty;

    assign top   = sp[PTR_W-1:0] - 1'b1;
    assign full  = sp == CNT_W'(DEPTH);
    assign empty = sp == '0;

    always_ff @(posedge clk)
        if (push && !full) mem[sp[PTR_W-1:0]] <= in;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sp  <= '0;
            out <= '0;
        end else if (push && !full) begin
            sp <= sp + 1'b1;
        end else if (pop && !empty) begin
            sp  <= sp - 1'b1;
            out <= mem[top];
        end
endmodule

// File: rtl/ret_stack_ctrl.sv
// ret_stack_ctrl: serves call/ret requests against an external LIFO stack,
// tracking occupancy and sticky overflow/underflow errors; all outputs registered
module ret_stack_ctrl
    import ca_stack_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             call_valid,
    input  ret_addr_t        call_addr,
    input  logic             ret_valid,
    input  logic             err_clr,
    output logic             ready,
    output logic             ret_addr_valid,
    output ret_addr_t        ret_addr,
    output logic [CNT_W-1:0] count,
    output logic             err_overflow,
    output logic             err_underflow,
    output ret_addr_t        stk_in,
    output logic             stk_push,
    output logic             stk_pop,
    input  ret_addr_t        stk_out
);
    stk_state_t state;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state          <= IDLE;
            ready          <= 1'b1;
            ret_addr_valid <= 1'b0;
            ret_addr       <= '0;
            count          <= '0;
            err_overflow   <= 1'b0;
            err_underflow  <= 1'b0;
            stk_in         <= '0;
            stk_push       <= 1'b0;
            stk_pop        <= 1'b0;
        end else begin
            stk_push       <= 1'b0;
            stk_pop        <= 1'b0;
            ret_addr_valid <= 1'b0;
            if (err_clr) begin
                err_overflow  <= 1'b0;
                err_underflow <= 1'b0;
            end
            // error sets below come after the clear so a coincident new error wins
            case (state)
                IDLE:
                    if (ready && ret_valid) begin
                        ready <= 1'b0;
                        if (count == '0) begin
                            ret_addr       <= '0;
                            ret_addr_valid <= 1'b1;
                            err_underflow  <= 1'b1;
                            state          <= RESP;
                        end else begin
                            stk_pop <= 1'b1;
                            state   <= POP;
                        end
                    end else if (ready && call_valid) begin
                        if (count == CNT_W'(DEPTH)) begin
                            err_overflow <= 1'b1;
                        end else begin
                            ready    <= 1'b0;
                            stk_in   <= call_addr;
                            stk_push <= 1'b1;
                            state    <= PUSH;
                        end
                    end
                PUSH: begin
                    count <= count + 1'b1;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                POP: begin
                    count <= count - 1'b1;
                    state <= WAIT;
                end
                WAIT: begin
                    ret_addr       <= stk_out;
                    ret_addr_valid <= 1'b1;
                    state          <= RESP;
                end
                RESP: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
endmodule

// File: tb/tb_ret_stack_ctrl.sv
// tb_ret_stack_ctrl: directed scenarios for ret_stack_ctrl paired with the ca_stack LIFO
module tb_ret_stack_ctrl;
    import ca_stack_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             call_valid = 1'b0;
    ret_addr_t        call_addr = '0;
    logic             ret_valid = 1'b0;
    logic             err_clr = 1'b0;
    logic             ready, ret_addr_valid, err_overflow, err_underflow, stk_push, stk_pop;
    ret_addr_t        ret_addr, stk_in, stk_out;
    logic [CNT_W-1:0] count;

    int errors = 0;
    int checks = 0;
    int n_push = 0;
    int n_pop  = 0;

    ret_stack_ctrl dut (
        .clk(clk), .rst(rst), .call_valid(call_valid), .call_addr(call_addr),
        .ret_valid(ret_valid), .err_clr(err_clr), .ready(ready),
        .ret_addr_valid(ret_addr_valid), .ret_addr(ret_addr), .count(count),
        .err_overflow(err_overflow), .err_underflow(err_underflow),
        .stk_in(stk_in), .stk_push(stk_push), .stk_pop(stk_pop), .stk_out(stk_out)
    );

    ca_stack stack (
        .clk(clk), .rst(rst), .push(stk_push), .pop(stk_pop), .in(stk_in), .out(stk_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (stk_push) n_push++;
        if (stk_pop) n_pop++;
        if (stk_push && stk_pop) begin
            errors++;
            $display("FAIL push_pop_overlap: push=%b pop=%b want not both", stk_push, stk_pop);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_call(input ret_addr_t a, input logic [CNT_W-1:0] exp_cnt, input string tag);
        call_valid = 1'b1;
        call_addr  = a;
        tick();
        call_valid = 1'b0;
        checks++;
        if (stk_push !== 1'b1 || stk_in !== a || ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_push: push=%b in=%h ready=%b want push=1 in=%h ready=0", tag, stk_push, stk_in, ready, a);
        end
        tick();
        checks++;
        if (count !== exp_cnt || ready !== 1'b1 || stk_push !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: count=%0d ready=%b push=%b want count=%0d ready=1 push=0", tag, count, ready, stk_push, exp_cnt);
        end
    endtask

    task automatic do_ret(input ret_addr_t exp, input logic [CNT_W-1:0] exp_cnt, input string tag);
        ret_valid = 1'b1;
        tick();
        ret_valid = 1'b0;
        checks++;
        if (stk_pop !== 1'b1 || ret_addr_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_pop: pop=%b valid=%b want pop=1 valid=0", tag, stk_pop, ret_addr_valid);
        end
        tick();
        checks++;
        if (count !== exp_cnt || stk_pop !== 1'b0 || ret_addr_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_wait: count=%0d pop=%b valid=%b want count=%0d pop=0 valid=0", tag, count, stk_pop, ret_addr_valid, exp_cnt);
        end
        tick();
        checks++;
        if (ret_addr_valid !== 1'b1 || ret_addr !== exp) begin
            errors++;
            $display("FAIL %s_resp: valid=%b addr=%h want valid=1 addr=%h", tag, ret_addr_valid, ret_addr, exp);
        end
        tick();
        checks++;
        if (ret_addr_valid !== 1'b0 || ready !== 1'b1 || ret_addr !== exp) begin
            errors++;
            $display("FAIL %s_idle: valid=%b ready=%b addr=%h want valid=0 ready=1 addr=%h", tag, ret_addr_valid, ready, ret_addr, exp);
        end
    endtask

    task automatic do_underflow(input string tag);
        int p;
        p = n_pop;
        ret_valid = 1'b1;
        tick();
        ret_valid = 1'b0;
        checks++;
        if (ret_addr_valid !== 1'b1 || ret_addr !== '0 || err_underflow !== 1'b1 || stk_pop !== 1'b0) begin
            errors++;
            $display("FAIL %s_resp: valid=%b addr=%h uf=%b pop=%b want 1 000 1 0", tag, ret_addr_valid, ret_addr, err_underflow, stk_pop);
        end
        tick();
        checks++;
        if (ret_addr_valid !== 1'b0 || ready !== 1'b1 || count !== '0 || n_pop != p) begin
            errors++;
            $display("FAIL %s_after: valid=%b ready=%b count=%0d pops=%0d want 0 1 0 %0d", tag, ret_addr_valid, ready, count, n_pop, p);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (stk_push !== 1'b0 || stk_pop !== 1'b0 || ret_addr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: push=%b pop=%b valid=%b want 0 0 0", stk_push, stk_pop, ret_addr_valid);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (ready !== 1'b1 || count !== '0 || ret_addr !== '0 || stk_in !== '0 ||
            err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b count=%0d addr=%h in=%h of=%b uf=%b want 1 0 000 000 0 0",
                     ready, count, ret_addr, stk_in, err_overflow, err_underflow);
        end
    endtask

    task automatic test_call_ret();
        do_call(12'h123, 4'd1, "t1_call1");
        do_call(12'h456, 4'd2, "t1_call2");
        do_ret(12'h456, 4'd1, "t1_ret1");
        do_ret(12'h123, 4'd0, "t1_ret2");
    endtask

    task automatic test_overflow();
        int p;
        for (int i = 1; i <= 8; i++) do_call(ret_addr_t'(i), CNT_W'(i), "t2_fill");
        p = n_push;
        call_valid = 1'b1;
        call_addr  = 12'hFFF;
        tick();
        call_valid = 1'b0;
        checks++;
        if (err_overflow !== 1'b1 || count !== 4'd8 || stk_push !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL t2_overflow: of=%b count=%0d push=%b ready=%b want 1 8 0 1", err_overflow, count, stk_push, ready);
        end
        tick();
        checks++;
        if (n_push != p || count !== 4'd8) begin
            errors++;
            $display("FAIL t2_no_push: pushes=%0d count=%0d want %0d 8", n_push, count, p);
        end
        do_ret(12'h008, 4'd7, "t2_ret8");
        for (int i = 7; i >= 1; i--) do_ret(ret_addr_t'(i), CNT_W'(i - 1), "t2_drain");
    endtask

    task automatic test_underflow();
        do_underflow("t3_underflow");
    endtask

    task automatic test_both_valid();
        int n;
        do_call(12'hABC, 4'd1, "t4_call");
        call_valid = 1'b1;
        call_addr  = 12'h321;
        ret_valid  = 1'b1;
        tick();
        ret_valid = 1'b0;
        checks++;
        if (stk_pop !== 1'b1 || stk_push !== 1'b0) begin
            errors++;
            $display("FAIL t4_ret_first: pop=%b push=%b want 1 0", stk_pop, stk_push);
        end
        tick();
        tick();
        checks++;
        if (ret_addr_valid !== 1'b1 || ret_addr !== 12'hABC || count !== '0) begin
            errors++;
            $display("FAIL t4_ret_resp: valid=%b addr=%h count=%0d want 1 abc 0", ret_addr_valid, ret_addr, count);
        end
        n = 0;
        while (!ready && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL t4_ready_timeout: ready=%b want 1", ready);
        end
        tick();
        call_valid = 1'b0;
        checks++;
        if (stk_push !== 1'b1 || stk_in !== 12'h321) begin
            errors++;
            $display("FAIL t4_held_call: push=%b in=%h want 1 321", stk_push, stk_in);
        end
        tick();
        checks++;
        if (count !== 4'd1 || ready !== 1'b1) begin
            errors++;
            $display("FAIL t4_count: count=%0d ready=%b want 1 1", count, ready);
        end
        do_ret(12'h321, 4'd0, "t4_drain");
    endtask

    task automatic test_reset_mid();
        bit seen;
        do_call(12'h055, 4'd1, "t5_call");
        ret_valid = 1'b1;
        tick();
        ret_valid = 1'b0;
        tick();
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen |= ret_addr_valid;
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen |= ret_addr_valid;
        end
        checks++;
        if (seen !== 1'b0 || count !== '0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL t5_reset_mid: pulse_seen=%b count=%0d ready=%b want 0 0 1", seen, count, ready);
        end
    endtask

    task automatic test_err_clr();
        for (int i = 1; i <= 8; i++) do_call(ret_addr_t'(16 + i), CNT_W'(i), "t6_fill");
        call_valid = 1'b1;
        call_addr  = 12'h777;
        tick();
        call_valid = 1'b0;
        for (int i = 8; i >= 1; i--) do_ret(ret_addr_t'(16 + i), CNT_W'(i - 1), "t6_drain");
        do_underflow("t6_uf");
        checks++;
        if (err_overflow !== 1'b1 || err_underflow !== 1'b1) begin
            errors++;
            $display("FAIL t6_both_set: of=%b uf=%b want 1 1", err_overflow, err_underflow);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL t6_cleared: of=%b uf=%b want 0 0", err_overflow, err_underflow);
        end
        err_clr   = 1'b1;
        ret_valid = 1'b1;
        tick();
        err_clr   = 1'b0;
        ret_valid = 1'b0;
        checks++;
        if (err_underflow !== 1'b1 || err_overflow !== 1'b0 || ret_addr_valid !== 1'b1) begin
            errors++;
            $display("FAIL t6_new_wins: uf=%b of=%b valid=%b want 1 0 1", err_underflow, err_overflow, ret_addr_valid);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_both_valid();
        test_reset_mid();
        test_err_clr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
